// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer: stage-register stall/flush control for the 5-stage MIPS pipeline
module pipeline_hazard_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [4:0]       ex_writereg,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             bubble_memwb,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3;
  localparam int DW = $clog2(DRAIN_CYCLES) > 0 ? $clog2(DRAIN_CYCLES) : 1;
  localparam int WW = $clog2(MEM_TIMEOUT) > 0 ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [DW-1:0] DLOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT - 1);
  logic [1:0] state;
  logic [DW-1:0] dcnt;
  logic [WW-1:0] wcnt;
  logic [CNT_W-1:0] cnt;
  logic live, to_flag, act, hlt, drn, mem_busy, load_use, fl, lu;
  // outputs stay quiet in the reset cycle and the one cycle after it
  assign act = live & reset_n;
  assign hlt = state == HALTED;
  assign drn = state == DRAIN;
  assign mem_busy = act & !hlt & mem_access & !dmem_ready;
  assign load_use = ex_memtoreg & ex_regwrite & (ex_writereg != 5'd0) & !id_jump &
                    ((ex_writereg == id_rs) | (id_uses_rt & (ex_writereg == id_rt)));
  assign fl = act & !hlt & !mem_busy;
  assign lu = fl & !ex_branch_taken & load_use;
  always_comb begin
    stall_pc     = (act & (hlt | drn)) | mem_busy | lu;
    stall_ifid   = mem_busy | lu;
    stall_idex   = mem_busy;
    stall_exmem  = mem_busy;
    bubble_memwb = mem_busy;
    flush_ifid   = (act & hlt) | (fl & (ex_branch_taken | id_jump | drn));
    flush_idex   = fl & (ex_branch_taken | load_use);
    halted       = act & hlt;
    mem_timeout  = act & to_flag;
    stall_cycles = reset_n ? cnt : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= RUN;
      live    <= 1'b0;
      dcnt    <= '0;
      wcnt    <= '0;
      to_flag <= 1'b0;
      cnt     <= '0;
    end else begin
      live <= 1'b1;
      if (live) begin
        wcnt <= mem_busy ? (wcnt == WMAX ? wcnt : wcnt + 1'b1) : '0;
        if (mem_busy && wcnt == WMAX) to_flag <= 1'b1;
        if (stall_pc && cnt != '1) cnt <= cnt + 1'b1;
        case (state)
          RUN: begin
            if (mem_busy) state <= MEM_WAIT;
            else if (halt_req) begin
              state <= DRAIN;
              dcnt  <= DLOAD;
            end
          end
          MEM_WAIT: begin
            if (!mem_busy) begin
              state <= halt_req ? DRAIN : RUN;
              dcnt  <= DLOAD;
            end
          end
          DRAIN: begin
            if (!mem_busy) begin
              if (dcnt == '0) state <= HALTED;
              else dcnt <= dcnt - 1'b1;
            end
          end
          default: if (!halt_req) state <= RUN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb_pipeline_hazard_sequencer: directed scoreboard bench for pipeline_hazard_sequencer
module tb_pipeline_hazard_sequencer;
  typedef struct packed {
    logic [8:0]  o;
    logic [31:0] sc;
  } exp_t;
  // bit order: stall_pc stall_ifid stall_idex stall_exmem flush_ifid flush_idex bubble_memwb halted mem_timeout
  localparam logic [8:0] Z  = 9'b000000000;
  localparam logic [8:0] LU = 9'b110001000;
  localparam logic [8:0] BR = 9'b000011000;
  localparam logic [8:0] JP = 9'b000010000;
  localparam logic [8:0] MB = 9'b111100100;
  localparam logic [8:0] DR = 9'b100010000;
  localparam logic [8:0] HL = 9'b100010010;
  localparam logic [8:0] TO = 9'b000000001;
  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] id_rs, id_rt, ex_writereg;
  logic id_uses_rt, id_jump, ex_regwrite, ex_memtoreg, ex_branch_taken;
  logic mem_access, dmem_ready, halt_req;
  logic stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex;
  logic bubble_memwb, halted, mem_timeout;
  logic [31:0] stall_cycles;
  logic [8:0] outs;
  logic [31:0] sc_model = '0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  pipeline_hazard_sequencer #(.DRAIN_CYCLES(4), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_writereg(ex_writereg), .ex_branch_taken(ex_branch_taken), .mem_access(mem_access),
    .dmem_ready(dmem_ready), .halt_req(halt_req), .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .stall_idex(stall_idex), .stall_exmem(stall_exmem), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .bubble_memwb(bubble_memwb), .halted(halted),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );
  assign outs = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex,
                 bubble_memwb, halted, mem_timeout};
  always #5 clk = ~clk;
  task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic jmp,
                     input logic rw, input logic m2r, input logic [4:0] wr, input logic br,
                     input logic ma, input logic rdy, input logic hr);
    id_rs = rs; id_rt = rt; id_uses_rt = urt; id_jump = jmp; ex_regwrite = rw;
    ex_memtoreg = m2r; ex_writereg = wr; ex_branch_taken = br; mem_access = ma;
    dmem_ready = rdy; halt_req = hr;
  endtask
  task automatic idle(input logic hr);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, hr);
  endtask
  task automatic cyc(input string tag, input logic [8:0] e);
    exp_t x;
    if (!reset_n) sc_model = '0;
    q.push_back('{o: e, sc: sc_model});
    @(negedge clk);
    x = q.pop_front();
    checks++;
    assert (outs === x.o) else begin
      errors++;
      $error("FAIL %s outs=%b expected=%b", tag, outs, x.o);
    end
    checks++;
    assert (stall_cycles === x.sc) else begin
      errors++;
      $error("FAIL %s_cnt stall_cycles=%0d expected=%0d", tag, stall_cycles, x.sc);
    end
    if (reset_n && e[8]) sc_model++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset_n = 1'b0;
    idle(1'b0);
    repeat (2) @(posedge clk);
    #1;
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("rst_cycle", Z);
    reset_n = 1'b1;
    cyc("post_rst", Z);
    idle(1'b0);
    cyc("idle", Z);
    drv(5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("lu_rs", LU);
    idle(1'b0);
    cyc("lu_release", Z);
    drv(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("lu_r0", Z);
    drv(5'd1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("rt_unused", Z);
    drv(5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("lu_rt", LU);
    drv(5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("br_over_lu", BR);
    drv(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("jump", JP);
    drv(5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("jump_masks_lu", JP);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("memwait3", MB);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("mem_done", Z);
    idle(1'b0);
    cyc("run_after_mem", Z);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("busy_over_br", MB);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("br_after_busy", BR);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc("memwait4", MB);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("timeout_set", TO);
    idle(1'b0);
    cyc("timeout_sticky", TO);
    idle(1'b1);
    cyc("halt_req", TO);
    idle(1'b0);
    for (int i = 0; i < 4; i++) cyc("drain", DR | TO);
    drv(5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc("halted_hold", HL | TO);
    drv(5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("halted_exit", HL | TO);
    idle(1'b0);
    cyc("resume", TO);
    idle(1'b1);
    cyc("halt_req2", TO);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("drain_busy", MB | TO);
    drv(5'd2, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc("drain_lu", LU | DR | TO);
    idle(1'b0);
    cyc("drain2", DR | TO);
    reset_n = 1'b0;
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc("rst_in_drain", Z);
    reset_n = 1'b1;
    idle(1'b1);
    cyc("post_rst2", Z);
    idle(1'b0);
    cyc("run_after_rst", Z);
    cyc("run_idle", Z);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
